// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// instruction field codes, ALU control values and the condition-code evaluator.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_e;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // nzcv ordered {N,Z,C,V}; the reserved 1111 condition never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: res = z;
      COND_NE: res = ~z;
      COND_CS: res = c;
      COND_CC: res = ~c;
      COND_MI: res = n;
      COND_PL: res = ~n;
      COND_VS: res = v;
      COND_VC: res = ~v;
      COND_HI: res = c & ~z;
      COND_LS: res = ~c | z;
      COND_GE: res = (n == v);
      COND_LT: res = (n != v);
      COND_GT: res = ~z & (n == v);
      COND_LE: res = z | (n != v);
      COND_AL: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cond_logic.sv
// NZCV flag register, condition evaluation and gating of every architectural
// write enable (including forcing them low while reset is asserted).
module cond_logic
  import arm_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond,
  input  logic [3:0] aluflags,
  input  logic [1:0] flagw,
  input  logic       flag_en,
  input  logic       nextpc,
  input  logic       branch,
  input  logic       regw,
  input  logic       memw,
  input  logic       irw,
  input  logic       rd_is_pc,
  input  logic       nowrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       irwrite
);

  logic [3:0] flags_q, flags_d;
  logic       condex;
  logic       pcs;

  assign condex = cond_eval(cond, flags_q);

  // Flags only move at the end of an execute cycle, so condex sees new flags next cycle.
  always_comb begin
    flags_d = flags_q;
    if (flag_en && flagw[1] && condex) flags_d[3:2] = aluflags[3:2];
    if (flag_en && flagw[0] && condex) flags_d[1:0] = aluflags[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign pcs      = (rd_is_pc & regw) | branch;
  assign pcwrite  = ~reset & (nextpc | (pcs & condex));
  assign regwrite = ~reset & regw & condex & ~nowrite;
  assign memwrite = ~reset & memw & condex;
  assign irwrite  = ~reset & irw;

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset control unit: main FSM with Moore control outputs and
// the ALU command decoder; flags and write gating live in cond_logic.
module mc_controller
  import arm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] instr,
  input  logic [3:0]  aluflags,
  output logic        pcwrite,
  output logic        memwrite,
  output logic        regwrite,
  output logic        irwrite,
  output logic        adrsrc,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  resultsrc,
  output logic [1:0]  alucontrol,
  output logic [1:0]  immsrc,
  output logic [1:0]  regsrc
);

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] cmd;
  logic       unused_rn;

  assign cond      = instr[19:16];
  assign op        = instr[15:14];
  assign funct     = instr[13:8];
  assign rd        = instr[3:0];
  assign cmd       = funct[4:1];
  assign unused_rn = ^instr[7:4];

  state_e state_q, state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  logic nextpc, branch, regw, memw, irw, aluop;

  always_comb begin
    nextpc    = 1'b0;
    branch    = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    irw       = 1'b0;
    aluop     = 1'b0;
    adrsrc    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    resultsrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irw       = 1'b1;
        nextpc    = 1'b1;
      end
      S_DECODE: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      S_MEMADR:   alusrcb = 2'b01;
      S_MEMREAD:  adrsrc  = 1'b1;
      S_MEMWB: begin
        resultsrc = 2'b01;
        regw      = 1'b1;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        memw   = 1'b1;
      end
      S_EXECUTER: aluop = 1'b1;
      S_EXECUTEI: begin
        alusrcb = 2'b01;
        aluop   = 1'b1;
      end
      S_ALUWB:    regw = 1'b1;
      S_BRANCH: begin
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  logic [1:0] flagw;
  logic       nowrite;

  always_comb begin
    alucontrol = ALU_ADD;
    flagw      = 2'b00;
    if (aluop) begin
      case (cmd)
        CMD_ADD: alucontrol = ALU_ADD;
        CMD_SUB: alucontrol = ALU_SUB;
        CMD_AND: alucontrol = ALU_AND;
        CMD_ORR: alucontrol = ALU_ORR;
        CMD_CMP: alucontrol = ALU_SUB;
        default: alucontrol = ALU_ADD;
      endcase
      flagw[1] = funct[0];
      flagw[0] = funct[0] & ((cmd == CMD_ADD) | (cmd == CMD_SUB) | (cmd == CMD_CMP));
    end
  end

  // Decoded for the whole instruction so CMP still suppresses the ALUWB write.
  assign nowrite = (op == OP_DP) && (cmd == CMD_CMP);

  assign immsrc = op;
  assign regsrc = {op == OP_MEM, op == OP_BR};

  cond_logic u_cond (
    .clk      (clk),
    .reset    (reset),
    .cond     (cond),
    .aluflags (aluflags),
    .flagw    (flagw),
    .flag_en  ((state_q == S_EXECUTER) || (state_q == S_EXECUTEI)),
    .nextpc   (nextpc),
    .branch   (branch),
    .regw     (regw),
    .memw     (memw),
    .irw      (irw),
    .rd_is_pc (rd == 4'b1111),
    .nowrite  (nowrite),
    .pcwrite  (pcwrite),
    .regwrite (regwrite),
    .memwrite (memwrite),
    .irwrite  (irwrite)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Directed-vector bench for mc_controller: each cycle's expected control word
// is queued by the stimulus and checked by an independent negedge monitor.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [19:0] instr;
  logic [3:0]  aluflags;
  logic        pcwrite, memwrite, regwrite, irwrite;
  logic        adrsrc, alusrca;
  logic [1:0]  alusrcb, resultsrc, alucontrol, immsrc, regsrc;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .aluflags   (aluflags),
    .pcwrite    (pcwrite),
    .memwrite   (memwrite),
    .regwrite   (regwrite),
    .irwrite    (irwrite),
    .adrsrc     (adrsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .alucontrol (alucontrol),
    .immsrc     (immsrc),
    .regsrc     (regsrc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4,
                 T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7, T_ALUWB = 8, T_BRANCH = 9,
                 T_UNK = 10;

  localparam logic [19:0] I_LDR    = 20'hE5912;
  localparam logic [19:0] I_SUBS   = 20'hE0532;
  localparam logic [19:0] I_BEQ    = 20'h0A000;
  localparam logic [19:0] I_CMP    = 20'hE1510;
  localparam logic [19:0] I_STREQ  = 20'h05821;
  localparam logic [19:0] I_STR    = 20'hE5821;
  localparam logic [19:0] I_MOVPC  = 20'hE1A0F;
  localparam logic [19:0] I_ORRI   = 20'hE3811;
  localparam logic [19:0] I_ADDSEQ = 20'h00912;
  localparam logic [19:0] I_UNK    = 20'hEC000;

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  // Expected mux selects {adrsrc, alusrca, alusrcb, resultsrc} per state.
  function automatic logic [5:0] sel_of(input int st);
    case (st)
      T_FETCH:    return 6'b0_1_10_10;
      T_DECODE:   return 6'b0_1_10_10;
      T_MEMADR:   return 6'b0_0_01_00;
      T_MEMREAD:  return 6'b1_0_00_00;
      T_MEMWB:    return 6'b0_0_00_01;
      T_MEMWRITE: return 6'b1_0_00_00;
      T_EXECI:    return 6'b0_0_01_00;
      T_BRANCH:   return 6'b0_0_01_10;
      default:    return 6'b0_0_00_00;
    endcase
  endfunction

  // w = {pcwrite, memwrite, regwrite, irwrite}; fl = registered NZCV seen this cycle.
  task automatic step(input string nm, input logic rst, input logic [19:0] ins,
                      input logic [3:0] af, input int st, input logic [3:0] w,
                      input logic [1:0] ac, input logic [3:0] fl);
    logic [1:0] op;
    @(posedge clk);
    #1;
    reset    = rst;
    instr    = ins;
    aluflags = af;
    op = ins[15:14];
    exp_q.push_back({w, sel_of(st), ac, op, (op == 2'b01), (op == 2'b10), fl});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [19:0] e, a;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {pcwrite, memwrite, regwrite, irwrite, adrsrc, alusrca, alusrcb, resultsrc,
           alucontrol, immsrc, regsrc, dut.u_cond.flags_q};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", n, a, e);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    instr    = 20'h0;
    aluflags = 4'h0;

    for (int i = 0; i < 3; i++) step("reset_hold", 1, 20'h0, 4'h0, T_FETCH, 4'b0000, 2'b00, 4'h0);

    step("ldr_fetch", 0, I_LDR, 4'h0, T_FETCH,   4'b1001, 2'b00, 4'h0);
    step("ldr_dec",   0, I_LDR, 4'h0, T_DECODE,  4'b0000, 2'b00, 4'h0);
    step("ldr_adr",   0, I_LDR, 4'h0, T_MEMADR,  4'b0000, 2'b00, 4'h0);
    step("ldr_read",  0, I_LDR, 4'h0, T_MEMREAD, 4'b0000, 2'b00, 4'h0);
    step("ldr_wb",    0, I_LDR, 4'h0, T_MEMWB,   4'b0010, 2'b00, 4'h0);

    step("subs_fetch", 0, I_SUBS, 4'b0100, T_FETCH,  4'b1001, 2'b00, 4'h0);
    step("subs_dec",   0, I_SUBS, 4'b0100, T_DECODE, 4'b0000, 2'b00, 4'h0);
    step("subs_exec",  0, I_SUBS, 4'b0100, T_EXECR,  4'b0000, 2'b01, 4'h0);
    step("subs_wb",    0, I_SUBS, 4'b0100, T_ALUWB,  4'b0010, 2'b00, 4'b0100);

    step("beq_fetch",  0, I_BEQ, 4'h0, T_FETCH,  4'b1001, 2'b00, 4'b0100);
    step("beq_dec",    0, I_BEQ, 4'h0, T_DECODE, 4'b0000, 2'b00, 4'b0100);
    step("beq_taken",  0, I_BEQ, 4'h0, T_BRANCH, 4'b1000, 2'b00, 4'b0100);

    step("cmp_fetch",  0, I_CMP, 4'b0010, T_FETCH,  4'b1001, 2'b00, 4'b0100);
    step("cmp_dec",    0, I_CMP, 4'b0010, T_DECODE, 4'b0000, 2'b00, 4'b0100);
    step("cmp_exec",   0, I_CMP, 4'b0010, T_EXECR,  4'b0000, 2'b01, 4'b0100);
    step("cmp_wb",     0, I_CMP, 4'b0010, T_ALUWB,  4'b0000, 2'b00, 4'b0010);

    step("streq_fetch", 0, I_STREQ, 4'h0, T_FETCH,    4'b1001, 2'b00, 4'b0010);
    step("streq_dec",   0, I_STREQ, 4'h0, T_DECODE,   4'b0000, 2'b00, 4'b0010);
    step("streq_adr",   0, I_STREQ, 4'h0, T_MEMADR,   4'b0000, 2'b00, 4'b0010);
    step("streq_wr",    0, I_STREQ, 4'h0, T_MEMWRITE, 4'b0000, 2'b00, 4'b0010);

    step("str_fetch", 0, I_STR, 4'h0, T_FETCH,    4'b1001, 2'b00, 4'b0010);
    step("str_dec",   0, I_STR, 4'h0, T_DECODE,   4'b0000, 2'b00, 4'b0010);
    step("str_adr",   0, I_STR, 4'h0, T_MEMADR,   4'b0000, 2'b00, 4'b0010);
    step("str_wr",    0, I_STR, 4'h0, T_MEMWRITE, 4'b0100, 2'b00, 4'b0010);

    step("movpc_fetch", 0, I_MOVPC, 4'hF, T_FETCH,  4'b1001, 2'b00, 4'b0010);
    step("movpc_dec",   0, I_MOVPC, 4'hF, T_DECODE, 4'b0000, 2'b00, 4'b0010);
    step("movpc_exec",  0, I_MOVPC, 4'hF, T_EXECR,  4'b0000, 2'b00, 4'b0010);
    step("movpc_wb",    0, I_MOVPC, 4'hF, T_ALUWB,  4'b1010, 2'b00, 4'b0010);

    step("orri_fetch", 0, I_ORRI, 4'h0, T_FETCH,  4'b1001, 2'b00, 4'b0010);
    step("orri_dec",   0, I_ORRI, 4'h0, T_DECODE, 4'b0000, 2'b00, 4'b0010);
    step("orri_exec",  0, I_ORRI, 4'h0, T_EXECI,  4'b0000, 2'b11, 4'b0010);
    step("orri_wb",    0, I_ORRI, 4'h0, T_ALUWB,  4'b0010, 2'b00, 4'b0010);

    step("addseq_fetch", 0, I_ADDSEQ, 4'b1101, T_FETCH,  4'b1001, 2'b00, 4'b0010);
    step("addseq_dec",   0, I_ADDSEQ, 4'b1101, T_DECODE, 4'b0000, 2'b00, 4'b0010);
    step("addseq_exec",  0, I_ADDSEQ, 4'b1101, T_EXECR,  4'b0000, 2'b00, 4'b0010);
    step("addseq_wb",    0, I_ADDSEQ, 4'b1101, T_ALUWB,  4'b0000, 2'b00, 4'b0010);

    step("unk_fetch", 0, I_UNK, 4'h0, T_FETCH,  4'b1001, 2'b00, 4'b0010);
    step("unk_dec",   0, I_UNK, 4'h0, T_DECODE, 4'b0000, 2'b00, 4'b0010);
    step("unk_state", 0, I_UNK, 4'h0, T_UNK,    4'b0000, 2'b00, 4'b0010);

    step("ldr2_fetch", 0, I_LDR, 4'h0, T_FETCH,   4'b1001, 2'b00, 4'b0010);
    step("ldr2_dec",   0, I_LDR, 4'h0, T_DECODE,  4'b0000, 2'b00, 4'b0010);
    step("ldr2_adr",   0, I_LDR, 4'h0, T_MEMADR,  4'b0000, 2'b00, 4'b0010);
    step("ldr2_read",  0, I_LDR, 4'h0, T_MEMREAD, 4'b0000, 2'b00, 4'b0010);
    step("rst_mid",    1, I_LDR, 4'h0, T_FETCH,   4'b0000, 2'b00, 4'h0);
    step("rst_mid2",   1, I_LDR, 4'h0, T_FETCH,   4'b0000, 2'b00, 4'h0);

    step("beq2_fetch", 0, I_BEQ, 4'h0, T_FETCH,  4'b1001, 2'b00, 4'h0);
    step("beq2_dec",   0, I_BEQ, 4'h0, T_DECODE, 4'b0000, 2'b00, 4'h0);
    step("beq2_nottk", 0, I_BEQ, 4'h0, T_BRANCH, 4'b0000, 2'b00, 4'h0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
